plic_gateway: RTL and testbench



---
 rtl/plic_gateway.sv | 156 +++++++++++++++
 tb/tb_plic_gateway.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/plic_gateway.sv
// plic_gateway: per-source interrupt gateway in front of the PLIC core.
// It synchronises the raw peripheral interrupt lines and turns edge- or
// level-triggered sources into level requests. Each source can have only one
// outstanding request. The next request is allowed after the PLIC claims and
// then completes that source ID. Edge sources count the edges that arrive while
// a request is outstanding, so no edge is lost. When a counter is saturated and
// another edge arrives, a sticky overflow flag is set.
//
// Ports:
//   clk, reset       clock; synchronous active-high reset
//   src_i            raw interrupt lines, bit i = source ID i (asynchronous)
//   claim_valid/id   PLIC claim performed this cycle and the ID it returned
//   complete_valid/id PLIC completion performed this cycle and its ID
//   ovf_clr          clears every ovf_o bit
//   req_o            level request per source (high while in REQ)
//   ovf_o            sticky per-source flag: an edge was dropped at saturation
module plic_gateway #(
    parameter int unsigned      NUM_SRC     = 3,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter logic [NUM_SRC:1] EDGE_SRC    = '0,
    parameter int unsigned      CNT_W       = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC:1]   src_i,
    input  logic               claim_valid,
    input  logic [5:0]         claim_id,
    input  logic               complete_valid,
    input  logic [5:0]         complete_id,
    input  logic               ovf_clr,
    output logic [NUM_SRC:1]   req_o,
    output logic [NUM_SRC:1]   ovf_o
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_INFLIGHT = 2'd2
    } state_e;

    logic [NUM_SRC:1] sync_q [SYNC_STAGES];
    logic [NUM_SRC:1] prev_q;
    logic [NUM_SRC:1] s;
    logic [NUM_SRC:1] rise;

    state_e           state_q [NUM_SRC:1];
    state_e           state_d [NUM_SRC:1];
    logic [CNT_W-1:0] cnt_q   [NUM_SRC:1];
    logic [CNT_W-1:0] cnt_d   [NUM_SRC:1];
    logic [NUM_SRC:1] ovf_q;
    logic [NUM_SRC:1] ovf_d;

    logic consumed;
    logic dec;
    logic inc;
    logic claim_hit;
    logic complete_hit;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            prev_q <= '0;
            ovf_q  <= '0;
            for (int unsigned i = 1; i <= NUM_SRC; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync_q[0] <= src_i;
            for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            prev_q <= s;
            ovf_q  <= ovf_d;
            for (int unsigned i = 1; i <= NUM_SRC; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    always_comb begin
        ovf_d = ovf_q & ~{NUM_SRC{ovf_clr}};
        for (int unsigned i = 1; i <= NUM_SRC; i++) begin
            state_d[i]   = state_q[i];
            cnt_d[i]     = cnt_q[i];
            consumed     = 1'b0;
            dec          = 1'b0;
            inc          = 1'b0;
            // IDs 0 and IDs above NUM_SRC never match any loop index.
            claim_hit    = claim_valid && (claim_id == 6'(i));
            complete_hit = complete_valid && (complete_id == 6'(i));

            case (state_q[i])
                ST_IDLE: begin
                    if (EDGE_SRC[i]) begin
                        // A fresh edge takes priority over a stored count.
                        // The fresh edge is used up directly, so the count
                        // is left unchanged.
                        if (rise[i]) begin
                            state_d[i] = ST_REQ;
                            consumed   = 1'b1;
                        end else if (cnt_q[i] != '0) begin
                            state_d[i] = ST_REQ;
                            dec        = 1'b1;
                        end
                    end else if (s[i]) begin
                        state_d[i] = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (claim_hit) begin
                        state_d[i] = ST_INFLIGHT;
                    end
                end
                ST_INFLIGHT: begin
                    if (complete_hit) begin
                        state_d[i] = ST_IDLE;
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                end
            endcase

            if (EDGE_SRC[i]) begin
                inc = rise[i] && !consumed;
                if (inc && !dec) begin
                    if (cnt_q[i] == '1) begin
                        // Setting the flag wins over an ovf_clr in the same cycle.
                        ovf_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end else if (dec && !inc) begin
                    cnt_d[i] = cnt_q[i] - CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        req_o = '0;
        for (int unsigned i = 1; i <= NUM_SRC; i++) begin
            req_o[i] = (state_q[i] == ST_REQ);
        end
    end

    assign ovf_o = ovf_q;

endmodule

// File: tb/tb_plic_gateway.sv
// tb_plic_gateway: directed bench for plic_gateway.
// The DUT is configured with three sources. Source 1 is level-triggered.
// Sources 2 and 3 are rising-edge sources, each with a 2-bit counter
// (saturation at 3).
module tb_plic_gateway;

    logic       clk;
    logic       reset;
    logic [3:1] src_i;
    logic       claim_valid;
    logic [5:0] claim_id;
    logic       complete_valid;
    logic [5:0] complete_id;
    logic       ovf_clr;
    logic [3:1] req_o;
    logic [3:1] ovf_o;

    int checks   = 0;
    int failures = 0;

    plic_gateway #(
        .NUM_SRC     (3),
        .SYNC_STAGES (2),
        .EDGE_SRC    (3'b110),
        .CNT_W       (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .src_i          (src_i),
        .claim_valid    (claim_valid),
        .claim_id       (claim_id),
        .complete_valid (complete_valid),
        .complete_id    (complete_id),
        .ovf_clr        (ovf_clr),
        .req_o          (req_o),
        .ovf_o          (ovf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [3:1] got, input logic [3:1] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic do_claim(input logic [5:0] id);
        claim_valid = 1'b1;
        claim_id    = id;
        tick(1);
        claim_valid = 1'b0;
        claim_id    = '0;
    endtask

    task automatic do_complete(input logic [5:0] id);
        complete_valid = 1'b1;
        complete_id    = id;
        tick(1);
        complete_valid = 1'b0;
        complete_id    = '0;
    endtask

    task automatic pulse(input int idx);
        src_i[idx] = 1'b1;
        tick(4);
        src_i[idx] = 1'b0;
        tick(4);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset          = 1'b1;
        src_i          = '0;
        claim_valid    = 1'b0;
        claim_id       = '0;
        complete_valid = 1'b0;
        complete_id    = '0;
        ovf_clr        = 1'b0;
        tick(2);
        chk("reset_req", req_o, 3'b000);
        chk("reset_ovf", ovf_o, 3'b000);
        reset = 1'b0;

        // Level source 1: latency, claim, re-request on complete
        src_i[1] = 1'b1;
        tick(2);
        chk("lvl_lat_e2", req_o, 3'b000);
        tick(1);
        chk("lvl_lat_e3", req_o, 3'b001);
        do_claim(6'd1);
        chk("lvl_claimed", req_o, 3'b000);
        do_complete(6'd1);
        chk("lvl_complete_idle", req_o, 3'b000);
        tick(1);
        chk("lvl_rerequest", req_o, 3'b001);

        // Illegal handshakes are ignored
        do_claim(6'd0);
        chk("claim_id0", req_o, 3'b001);
        do_claim(6'd7);
        chk("claim_id7", req_o, 3'b001);
        do_complete(6'd1);
        chk("complete_in_req", req_o, 3'b001);
        tick(1);
        chk("complete_in_req_hold", req_o, 3'b001);
        do_claim(6'd2);
        chk("claim_idle_src", req_o, 3'b001);

        // Edge source 2: counting edges while in flight
        pulse(2);
        chk("edge_req", req_o, 3'b011);
        do_claim(6'd2);
        chk("edge_claimed", req_o, 3'b001);
        pulse(2);
        pulse(2);
        pulse(2);
        chk("edge_inflight_hold", req_o, 3'b001);
        chk("edge_cnt3_no_ovf", ovf_o, 3'b000);
        for (int r = 0; r < 3; r++) begin
            do_complete(6'd2);
            chk("edge_round_idle", req_o, 3'b001);
            tick(1);
            chk("edge_round_req", req_o, 3'b011);
            do_claim(6'd2);
            chk("edge_round_claim", req_o, 3'b001);
        end
        do_complete(6'd2);
        tick(2);
        chk("edge_drained", req_o, 3'b001);

        // Same-cycle claim id1 (REQ) and complete id2 (INFLIGHT)
        pulse(2);
        chk("s5_src2_req", req_o, 3'b011);
        do_claim(6'd2);
        chk("s5_src2_claim", req_o, 3'b001);
        pulse(2);
        chk("s5_src2_pending", req_o, 3'b001);
        claim_valid    = 1'b1;
        claim_id       = 6'd1;
        complete_valid = 1'b1;
        complete_id    = 6'd2;
        tick(1);
        claim_valid    = 1'b0;
        complete_valid = 1'b0;
        chk("s5_both", req_o, 3'b000);
        tick(1);
        chk("s5_src2_rereq", req_o, 3'b010);
        do_complete(6'd1);
        chk("s5_src1_idle", req_o, 3'b010);
        tick(1);
        chk("s5_src1_rereq", req_o, 3'b011);

        // Claim and complete of the same REQ source: only the claim acts
        claim_valid    = 1'b1;
        claim_id       = 6'd1;
        complete_valid = 1'b1;
        complete_id    = 6'd1;
        tick(1);
        claim_valid    = 1'b0;
        complete_valid = 1'b0;
        chk("same_id_claim", req_o, 3'b010);
        tick(2);
        chk("same_id_inflight", req_o, 3'b010);
        do_complete(6'd1);
        tick(1);
        chk("same_id_done", req_o, 3'b011);
        do_claim(6'd2);
        chk("src2_inflight", req_o, 3'b001);

        // Edge source 3: saturation and overflow flag
        pulse(3);
        chk("sat_req", req_o, 3'b101);
        do_claim(6'd3);
        chk("sat_claim", req_o, 3'b001);
        for (int p = 0; p < 5; p++) pulse(3);
        chk("sat_req_hold", req_o, 3'b001);
        chk("sat_ovf_set", ovf_o, 3'b100);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        chk("ovf_cleared", ovf_o, 3'b000);
        src_i[3] = 1'b1;
        tick(2);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        chk("ovf_set_wins", ovf_o, 3'b100);
        src_i[3] = 1'b0;
        tick(4);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        chk("ovf_cleared2", ovf_o, 3'b000);
        for (int r = 0; r < 3; r++) begin
            do_complete(6'd3);
            chk("sat_round_idle", req_o, 3'b001);
            tick(1);
            chk("sat_round_req", req_o, 3'b101);
            do_claim(6'd3);
            chk("sat_round_claim", req_o, 3'b001);
        end
        do_complete(6'd3);
        tick(2);
        chk("sat_drained", req_o, 3'b001);

        // Reset mid-operation
        pulse(3);
        do_claim(6'd3);
        for (int p = 0; p < 4; p++) pulse(3);
        pulse(2);
        pulse(2);
        chk("pre_reset_req", req_o, 3'b001);
        chk("pre_reset_ovf", ovf_o, 3'b100);
        reset = 1'b1;
        tick(1);
        chk("mid_reset_req", req_o, 3'b000);
        chk("mid_reset_ovf", ovf_o, 3'b000);
        reset = 1'b0;
        tick(2);
        chk("post_reset_e2", req_o, 3'b000);
        tick(1);
        chk("post_reset_lvl", req_o, 3'b001);
        tick(2);
        chk("post_reset_cnt0", req_o, 3'b001);
        pulse(2);
        chk("post_reset_new_edge", req_o, 3'b011);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
